// File: rtl/simt_diverge_ctrl.sv
// SIMT divergence controller: owns the block's {pc, mask, reconv} and drives simt_stack push/pop.
// Optional SIMT_DIVERGE_STATS_EN adds saturating divergence/reconvergence counters.
module simt_diverge_ctrl #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int STACK_DEPTH       = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic                         instr_is_branch,
    input  logic [PC_BITS-1:0]           instr_next_pc,
    input  logic [PC_BITS-1:0]           br_target,
    input  logic [PC_BITS-1:0]           br_reconv,
    input  logic [THREADS_PER_BLOCK-1:0] br_taken_mask,
    output logic [PC_BITS-1:0]           cur_pc,
    output logic [THREADS_PER_BLOCK-1:0] cur_mask,
    output logic [PC_BITS-1:0]           cur_reconv,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [PC_BITS-1:0]           stk_push_pc,
    output logic [PC_BITS-1:0]           stk_push_reconvpc,
    output logic [THREADS_PER_BLOCK-1:0] stk_push_mask,
    input  logic [PC_BITS-1:0]           stk_tos_pc,
    input  logic [PC_BITS-1:0]           stk_tos_reconvpc,
    input  logic [THREADS_PER_BLOCK-1:0] stk_tos_mask,
    input  logic                         stk_full,
    output logic                         overflow_err,
`ifdef SIMT_DIVERGE_STATS_EN
    output logic [15:0]                  stat_diverge,
    output logic [15:0]                  stat_reconv,
`endif
    output logic [1:0]                   dbg_state,
    output logic [$clog2(STACK_DEPTH):0] dbg_depth
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;
    localparam int T  = THREADS_PER_BLOCK;

    typedef enum logic [1:0] {IDLE = 2'd0, PUSH_JOIN = 2'd1, PUSH_NT = 2'd2} state_t;

    state_t               r_state;
    logic [PC_BITS-1:0]   r_cur_pc;
    logic [T-1:0]         r_cur_mask;
    logic [PC_BITS-1:0]   r_cur_reconv;
    logic [DW-1:0]        r_depth;
    logic                 r_overflow;
    logic [PC_BITS-1:0]   r_lat_target;
    logic [PC_BITS-1:0]   r_lat_next_pc;
    logic [PC_BITS-1:0]   r_lat_reconv;
    logic [T-1:0]         r_lat_tk;
    logic [T-1:0]         r_lat_nt;
    logic [T-1:0]         r_lat_old_mask;
    logic [PC_BITS-1:0]   r_lat_old_reconv;

    logic                 w_idle;
    logic                 w_reconv_hit;
    logic [T-1:0]         w_tk;
    logic [T-1:0]         w_nt;
    logic                 w_room;
    logic                 w_push_join;
    logic                 w_push_nt;

    // Handshake: instr_* is consumed on a cycle where instr_valid && instr_ready;
    // ready is only high in IDLE when no reconvergence pop is pending.
    assign w_idle       = (r_state == IDLE);
    assign w_reconv_hit = (r_cur_pc == r_cur_reconv) && (r_depth != '0);
    assign instr_ready  = w_idle && !w_reconv_hit;
    assign stk_pop      = w_idle && w_reconv_hit;

    assign w_tk   = br_taken_mask & r_cur_mask;
    assign w_nt   = r_cur_mask & ~w_tk;
    assign w_room = (r_depth <= DW'(STACK_DEPTH - 2));

    assign w_push_join = (r_state == PUSH_JOIN);
    assign w_push_nt   = (r_state == PUSH_NT);
    assign stk_push    = w_push_join || w_push_nt;

    assign stk_push_pc       = w_push_join ? r_lat_reconv     : (w_push_nt ? r_lat_next_pc : '0);
    assign stk_push_mask     = w_push_join ? r_lat_old_mask   : (w_push_nt ? r_lat_nt      : '0);
    assign stk_push_reconvpc = w_push_join ? r_lat_old_reconv : (w_push_nt ? r_lat_reconv  : '0);

    assign cur_pc       = r_cur_pc;
    assign cur_mask     = r_cur_mask;
    assign cur_reconv   = r_cur_reconv;
    assign overflow_err = r_overflow;
    assign dbg_state    = r_state;
    assign dbg_depth    = r_depth;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_cur_pc         <= '0;
            r_cur_mask       <= '1;
            r_cur_reconv     <= '1;
            r_depth          <= '0;
            r_overflow       <= 1'b0;
            r_lat_target     <= '0;
            r_lat_next_pc    <= '0;
            r_lat_reconv     <= '0;
            r_lat_tk         <= '0;
            r_lat_nt         <= '0;
            r_lat_old_mask   <= '0;
            r_lat_old_reconv <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_reconv_hit) begin
                        r_cur_pc     <= stk_tos_pc;
                        r_cur_mask   <= stk_tos_mask;
                        r_cur_reconv <= stk_tos_reconvpc;
                        r_depth      <= r_depth - DW'(1);
                    end else if (instr_valid) begin
                        if (!instr_is_branch || (w_tk == '0)) begin
                            r_cur_pc <= instr_next_pc;
                        end else if (w_nt == '0) begin
                            r_cur_pc <= br_target;
                        end else if (w_room) begin
                            r_lat_target     <= br_target;
                            r_lat_next_pc    <= instr_next_pc;
                            r_lat_reconv     <= br_reconv;
                            r_lat_tk         <= w_tk;
                            r_lat_nt         <= w_nt;
                            r_lat_old_mask   <= r_cur_mask;
                            r_lat_old_reconv <= r_cur_reconv;
                            r_state          <= PUSH_JOIN;
                        end else begin
                            // No room for both entries: run the taken path only and flag it.
                            r_overflow <= 1'b1;
                            r_cur_pc   <= br_target;
                        end
                    end
                end
                PUSH_JOIN: begin
                    r_depth <= r_depth + DW'(1);
                    r_state <= PUSH_NT;
                end
                PUSH_NT: begin
                    r_depth      <= r_depth + DW'(1);
                    r_cur_pc     <= r_lat_target;
                    r_cur_mask   <= r_lat_tk;
                    r_cur_reconv <= r_lat_reconv;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SIMT_DIVERGE_STATS_EN
    logic [15:0] r_stat_diverge;
    logic [15:0] r_stat_reconv;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_diverge <= '0;
            r_stat_reconv  <= '0;
        end else begin
            if (w_push_nt && (r_stat_diverge != 16'hFFFF))
                r_stat_diverge <= r_stat_diverge + 16'd1;
            if (stk_pop && (r_stat_reconv != 16'hFFFF))
                r_stat_reconv <= r_stat_reconv + 16'd1;
        end
    end
    assign stat_diverge = r_stat_diverge;
    assign stat_reconv  = r_stat_reconv;
`endif

    // The stack must never be full when a push is issued; the depth guard guarantees it.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) stk_push |-> !stk_full);

endmodule
